// File: rtl/branch_ctrl.sv
// branch_ctrl -- decode-stage branch controller.
// Decodes the branch held in D, stalls it while a used source register is
// still being produced in E or M, and raises a same-cycle redirect with the
// computed target once the branch can resolve. Keeps saturating counters of
// resolved branches, taken branches and stall cycles.
//
// Ports:
//   clk, reset                  clock, async active-high reset
//   instr_D, valid_D, pc4_D     D-stage instruction, valid bit, PC+4
//   cmp_true                    external comparator result (forwarded operands)
//   we_E/a3_E/tnew_E            E-stage writer: write enable, dest, cycles-to-forward
//   we_M/a3_M/tnew_M            M-stage writer: same
//   is_branch                   D holds a supported branch
//   stall_br                    freeze PC and F/D, bubble into E
//   redirect, target            next PC is target (combinational)
//   br_cnt/taken_cnt/stall_cnt  saturating statistics counters
module branch_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr_D,
  input  logic             valid_D,
  input  logic [31:0]      pc4_D,
  input  logic             cmp_true,
  input  logic             we_E,
  input  logic             we_M,
  input  logic [4:0]       a3_E,
  input  logic [4:0]       a3_M,
  input  logic [1:0]       tnew_E,
  input  logic [1:0]       tnew_M,
  output logic             is_branch,
  output logic             stall_br,
  output logic             redirect,
  output logic [31:0]      target,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {IDLE, STALL} state_t;
  state_t state;

  logic [5:0]  op;
  logic [4:0]  rs, rt;
  logic        use_rt, br_op;
  logic        hz_rs, hz_rt, hz, resolve;

  assign op = instr_D[31:26];
  assign rs = instr_D[25:21];
  assign rt = instr_D[20:16];

  // Two-register compares read rt; every other supported branch ignores it,
  // so the rt field (which encodes bltz/bgez under REGIMM) must not stall.
  always_comb begin
    br_op  = 1'b0;
    use_rt = 1'b0;
    case (op)
      6'b000100, 6'b000101: begin br_op = 1'b1; use_rt = 1'b1; end
      6'b000110, 6'b000111: br_op = 1'b1;
      6'b000001:            br_op = (rt == 5'd0) || (rt == 5'd1);
      default:              br_op = 1'b0;
    endcase
  end

  assign is_branch = valid_D && br_op;

  // Branch reads operands in D (tuse=0), so any pending writer with tnew>0
  // blocks it. $0 is hard-wired and never a hazard.
  function automatic logic src_hz(input logic [4:0] r);
    return (r != 5'd0) &&
           ((we_E && a3_E == r && tnew_E != 2'd0) ||
            (we_M && a3_M == r && tnew_M != 2'd0));
  endfunction

  assign hz_rs    = src_hz(rs);
  assign hz_rt    = use_rt && src_hz(rt);
  assign hz       = is_branch && (hz_rs || hz_rt);
  assign stall_br = hz;
  assign resolve  = is_branch && !hz;
  assign redirect = resolve && cmp_true;

  // Target is sign-extended word offset added to PC+4, wrapping mod 2^32.
  assign target = pc4_D + {{14{instr_D[15]}}, instr_D[15:0], 2'b00};

  // Tracks whether the branch in D is waiting on a producer; counting is
  // purely event-driven so a stalled branch is counted only when it resolves.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else if (!is_branch) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    state <= hz ? STALL : IDLE;
        STALL:   state <= hz ? STALL : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      br_cnt    <= '0;
      taken_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (resolve  && br_cnt    != '1) br_cnt    <= br_cnt + 1'b1;
      if (redirect && taken_cnt != '1) taken_cnt <= taken_cnt + 1'b1;
      if (stall_br && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_ctrl.sv
module tb_branch_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_D, pc4_D;
  logic        valid_D, cmp_true, we_E, we_M;
  logic [4:0]  a3_E, a3_M;
  logic [1:0]  tnew_E, tnew_M;
  logic        is_branch, stall_br, redirect;
  logic [31:0] target;
  logic [15:0] br_cnt, taken_cnt, stall_cnt;
  logic        s_is_branch, s_stall_br, s_redirect;
  logic [31:0] s_target;
  logic [1:0]  s_br_cnt, s_taken_cnt, s_stall_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  branch_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .instr_D(instr_D), .valid_D(valid_D), .pc4_D(pc4_D),
    .cmp_true(cmp_true), .we_E(we_E), .we_M(we_M), .a3_E(a3_E), .a3_M(a3_M),
    .tnew_E(tnew_E), .tnew_M(tnew_M), .is_branch(is_branch), .stall_br(stall_br),
    .redirect(redirect), .target(target), .br_cnt(br_cnt), .taken_cnt(taken_cnt),
    .stall_cnt(stall_cnt));

  // Narrow-counter copy on the same stimulus, used to reach saturation quickly.
  branch_ctrl #(.CNT_W(2)) dut_s (
    .clk(clk), .reset(reset), .instr_D(instr_D), .valid_D(valid_D), .pc4_D(pc4_D),
    .cmp_true(cmp_true), .we_E(we_E), .we_M(we_M), .a3_E(a3_E), .a3_M(a3_M),
    .tnew_E(tnew_E), .tnew_M(tnew_M), .is_branch(s_is_branch), .stall_br(s_stall_br),
    .redirect(s_redirect), .target(s_target), .br_cnt(s_br_cnt), .taken_cnt(s_taken_cnt),
    .stall_cnt(s_stall_cnt));

  task automatic no_writers();
    we_E = 0; we_M = 0; a3_E = 0; a3_M = 0; tnew_E = 0; tnew_M = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk_cnt(input string nm, input logic [15:0] b, input logic [15:0] t, input logic [15:0] s);
    tests++;
    if (br_cnt !== b || taken_cnt !== t || stall_cnt !== s) begin
      fails++;
      $display("FAIL %s: got br=%0d taken=%0d stall=%0d, want br=%0d taken=%0d stall=%0d",
               nm, br_cnt, taken_cnt, stall_cnt, b, t, s);
    end
  endtask

  task automatic chk_comb(input string nm, input logic ib, input logic st, input logic rd);
    tests++;
    if (is_branch !== ib || stall_br !== st || redirect !== rd) begin
      fails++;
      $display("FAIL %s: got is_branch=%b stall=%b redirect=%b, want %b %b %b",
               nm, is_branch, stall_br, redirect, ib, st, rd);
    end
  endtask

  task automatic test_reset();
    reset = 1; valid_D = 1; cmp_true = 1; pc4_D = 32'h3004;
    instr_D = 32'h10220004; no_writers();
    #2;
    chk_cnt("reset_counters", 0, 0, 0);
    chk_comb("reset_comb_follows", 1, 0, 1);
    tests++;
    if (s_br_cnt !== 2'd0) begin fails++; $display("FAIL reset_small: got %0d want 0", s_br_cnt); end
    step();
    chk_cnt("reset_hold", 0, 0, 0);
    valid_D = 0;
    reset = 0;
  endtask

  task automatic test_unstalled();
    valid_D = 1; instr_D = 32'h10220004; pc4_D = 32'h3004; cmp_true = 1; no_writers();
    #1;
    chk_comb("beq_comb", 1, 0, 1);
    tests++;
    if (target !== 32'h3014) begin fails++; $display("FAIL beq_target: got %h want 00003014", target); end
    step();
    chk_cnt("beq_counts", 1, 1, 0);
  endtask

  task automatic test_load_use();
    valid_D = 1; instr_D = 32'h14600000; pc4_D = 32'h4000; cmp_true = 1;
    no_writers(); we_E = 1; a3_E = 3; tnew_E = 2;
    #1; chk_comb("lu_stall1", 1, 1, 0);
    step();
    no_writers(); we_M = 1; a3_M = 3; tnew_M = 1;
    #1; chk_comb("lu_stall2", 1, 1, 0);
    step();
    tnew_M = 0;
    #1; chk_comb("lu_resolve", 1, 0, 1);
    step();
    chk_cnt("lu_counts", 2, 2, 2);
  endtask

  task automatic test_zero_unused();
    valid_D = 1; instr_D = 32'h1885FFFF; pc4_D = 32'h3000; cmp_true = 0;
    no_writers(); we_E = 1; a3_E = 0; tnew_E = 1;
    #1; chk_comb("r0_no_stall", 1, 0, 0);
    tests++;
    if (target !== 32'h2FFC) begin fails++; $display("FAIL neg_target: got %h want 00002ffc", target); end
    step();
    a3_E = 5;
    #1; chk_comb("unused_rt_no_stall", 1, 0, 0);
    step();
    chk_cnt("zero_counts", 4, 2, 2);
  endtask

  task automatic test_regimm();
    valid_D = 1; instr_D = 32'h04220000; pc4_D = 32'h5000; cmp_true = 1; no_writers();
    #1; chk_comb("regimm_bad_rt", 0, 0, 0);
    step();
    chk_cnt("regimm_bad_counts", 4, 2, 2);
    instr_D = 32'h04210000; cmp_true = 0;
    #1; chk_comb("bgez_not_taken", 1, 0, 0);
    step();
    chk_cnt("bgez_counts", 5, 2, 2);
    valid_D = 0; instr_D = 32'h10220004; cmp_true = 1;
    #1; chk_comb("bubble_not_branch", 0, 0, 0);
    step();
    chk_cnt("bubble_counts", 5, 2, 2);
  endtask

  task automatic test_saturation();
    valid_D = 1; instr_D = 32'h10000001; pc4_D = 32'hFFFFFFFC; cmp_true = 1; no_writers();
    #1;
    tests++;
    if (target !== 32'h0) begin fails++; $display("FAIL wrap_target: got %h want 00000000", target); end
    step();
    chk_cnt("wrap_counts", 6, 3, 2);
    // beq $1,$2 with $2 pending in M for two cycles, then taken.
    instr_D = 32'h10220004; pc4_D = 32'h3004;
    we_M = 1; a3_M = 2; tnew_M = 1;
    #1; chk_comb("sat_stall", 1, 1, 0);
    step(); step();
    tnew_M = 0;
    step();
    chk_cnt("sat_big_counts", 7, 4, 4);
    tests++;
    if (s_br_cnt !== 2'd3 || s_taken_cnt !== 2'd3 || s_stall_cnt !== 2'd3) begin
      fails++;
      $display("FAIL saturate_small: got br=%0d taken=%0d stall=%0d want 3 3 3", s_br_cnt, s_taken_cnt, s_stall_cnt);
    end
  endtask

  task automatic test_reset_mid_stall();
    valid_D = 1; instr_D = 32'h10220004; pc4_D = 32'h3004; cmp_true = 1;
    no_writers(); we_E = 1; a3_E = 1; tnew_E = 2;
    step();
    chk_cnt("pre_reset_counts", 7, 4, 5);
    reset = 1;
    #1;
    chk_cnt("mid_stall_reset", 0, 0, 0);
    chk_comb("reset_stall_comb", 1, 1, 0);
    step();
    no_writers(); cmp_true = 0;
    reset = 0;
    #1; chk_comb("post_reset_resolve", 1, 0, 0);
    step();
    chk_cnt("post_reset_counts", 1, 0, 0);
    valid_D = 0;
    step();
    chk_cnt("post_reset_idle", 1, 0, 0);
  endtask

  initial begin
    test_reset();
    test_unstalled();
    test_load_use();
    test_zero_unused();
    test_regimm();
    test_saturation();
    test_reset_mid_stall();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
